// File: rtl/sevenseg_scan_decoder_if.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_decoder_if
// Multiplexed 7-segment display bus as seen between a display driver and a
// readback/monitor block.
//   anodes_i   [7:0]  active-low digit select, bit k low = digit k driven
//   segments_i [6:0]  active-low segments {g,f,e,d,c,b,a}
// Modports:
//   master : the display driver (drives the bus)
//   slave  : the scan decoder (samples the bus)
// The bus has no handshake: the driver owns both fields and may change them
// on any cycle; the receiver never back-pressures and must tolerate
// arbitrary, asynchronous transitions on every bit.
// ---------------------------------------------------------------------------
interface sevenseg_scan_decoder_if;
  logic [7:0] anodes_i;
  logic [6:0] segments_i;

  modport master (output anodes_i, output segments_i);
  modport slave  (input  anodes_i, input  segments_i);
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_decoder
// Receive side of a multiplexed 8-digit 7-segment display bus. Samples the
// scanned anode/segment lines, decodes each digit once its pattern has been
// stable for SETTLE cycles and publishes a complete 8-digit frame once every
// digit has been seen.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus (slave)     anodes_i[7:0], segments_i[6:0] from the display driver
//   digits_o        last complete frame, digit k in [4k+3:4k]
//   blank_mask_o    bit k = digit k was blank in the last frame
//   frame_valid_o   one-cycle pulse when digits_o updates
//   digit_err_o     last frame held an invalid pattern or multi-anode event
//   stalled_o       no frame completed within TIMEOUT cycles
//   state_dbg       current scan FSM state (IDLE=0, SETTLING=1, HELD=2)
// ---------------------------------------------------------------------------
module sevenseg_scan_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 200000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sevenseg_scan_decoder_if.slave bus,
  output logic [31:0]            digits_o,
  output logic [7:0]             blank_mask_o,
  output logic                   frame_valid_o,
  output logic                   digit_err_o,
  output logic                   stalled_o,
  output logic [1:0]             state_dbg
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int SW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t          state;
  logic [14:0]     sync1, sync2, prev;
  logic [CW-1:0]   stab_cnt;
  logic [SW-1:0]   stall_cnt;
  logic [7:0]      seen, blank_acc;
  logic            err_pend;
  logic [31:0]     buffer;

  logic [7:0]      low;
  logic            all_high, one_hot, multi, changed, settle_hit;
  logic [2:0]      idx;
  logic [4:0]      dec;
  logic [7:0]      bit_mask, seen_next, blank_next;
  logic [31:0]     buf_next;
  logic            err_next;

  // {invalid, nibble}; anything outside the table decodes to E and is invalid
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0010000: decode = 5'h09;
      7'b1111111: decode = 5'h0F;
      default:    decode = 5'h1E;
    endcase
  endfunction

  // Two-flop synchronizer on all 15 lines, plus one more stage to compare
  // against the previous synchronized pattern. Reset value is the idle bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= {bus.anodes_i, bus.segments_i};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign changed = (sync2 != prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
    end else if (changed) begin
      stab_cnt <= '0;
    end else if (stab_cnt != CW'(SETTLE)) begin
      stab_cnt <= stab_cnt + CW'(1);
    end
  end

  // Capture happens on the edge where the count steps to SETTLE-1, which puts
  // a pattern stable at the pins into the frame SETTLE+2 cycles after it
  // first appears.
  assign settle_hit = !changed && (stab_cnt == CW'(SETTLE - 2));

  assign low      = ~sync2[14:7];
  assign all_high = (low == 8'd0);
  assign one_hot  = !all_high && ((low & (low - 8'd1)) == 8'd0);
  assign multi    = !all_high && !one_hot;

  always_comb begin
    idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (low[k]) idx = 3'(k);
    end
    dec                  = decode(sync2[6:0]);
    bit_mask             = 8'b1 << idx;
    seen_next            = seen | bit_mask;
    blank_next           = blank_acc | ((dec[3:0] == 4'hF) ? bit_mask : 8'd0);
    err_next             = err_pend | dec[4];
    buf_next             = buffer;
    buf_next[idx*4 +: 4] = dec[3:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      seen          <= '0;
      blank_acc     <= '0;
      err_pend      <= 1'b0;
      buffer        <= '0;
      stall_cnt     <= '0;
      digits_o      <= '0;
      blank_mask_o  <= '0;
      frame_valid_o <= 1'b0;
      digit_err_o   <= 1'b0;
    end else begin
      frame_valid_o <= 1'b0;
      if (stall_cnt != SW'(TIMEOUT)) stall_cnt <= stall_cnt + SW'(1);

      if (multi) begin
        err_pend <= 1'b1;
        state    <= IDLE;
      end else if (all_high) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: state <= SETTLING;
          SETTLING: begin
            if (settle_hit) begin
              state  <= HELD;
              buffer <= buf_next;
              if (seen_next == 8'hFF) begin
                // Frame completes on this capture: publish and start afresh.
                digits_o      <= buf_next;
                blank_mask_o  <= blank_next;
                digit_err_o   <= err_next;
                frame_valid_o <= 1'b1;
                seen          <= '0;
                blank_acc     <= '0;
                err_pend      <= 1'b0;
                stall_cnt     <= '0;
              end else begin
                seen      <= seen_next;
                blank_acc <= blank_next;
                err_pend  <= err_next;
              end
            end
          end
          HELD: if (changed) state <= SETTLING;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign stalled_o = (stall_cnt == SW'(TIMEOUT));
  assign state_dbg = state;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_sevenseg_scan_decoder
// Directed bench for sevenseg_scan_decoder (SETTLE=4, TIMEOUT=100). Scans
// frames digit 7 down to 0, each digit held 10 cycles with 2 blank cycles,
// and checks frames, blanks, errors, reset discard and the stall flag.
// ---------------------------------------------------------------------------
module tb_sevenseg_scan_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 100;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sevenseg_scan_decoder_if bus ();

  logic [31:0] digits_o;
  logic [7:0]  blank_mask_o;
  logic        frame_valid_o, digit_err_o, stalled_o;
  logic [1:0]  state_dbg;

  sevenseg_scan_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .digits_o      (digits_o),
    .blank_mask_o  (blank_mask_o),
    .frame_valid_o (frame_valid_o),
    .digit_err_o   (digit_err_o),
    .stalled_o     (stalled_o),
    .state_dbg     (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fv_count = 0;
  int fv_last  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: every published frame must match the oldest expected frame
  always @(negedge clk) begin
    if (frame_valid_o === 1'b1) begin
      fv_count <= fv_count + 1;
      fv_last  <= cyc;
      if (exp_q.size() > 0) check("sb_frame", digits_o, exp_q.pop_front());
      else                  check("sb_spurious_frame", 32'(exp_q.size()), 32'd1);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: seg_of = 7'b1000000;
      4'h1: seg_of = 7'b1111001;
      4'h2: seg_of = 7'b0100100;
      4'h3: seg_of = 7'b0110000;
      4'h4: seg_of = 7'b0011001;
      4'h5: seg_of = 7'b0010010;
      4'h6: seg_of = 7'b0000010;
      4'h7: seg_of = 7'b1111000;
      4'h8: seg_of = 7'b0000000;
      4'h9: seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // driver tasks: inputs change on the falling edge
  task automatic drive(input logic [7:0] an, input logic [6:0] sg, input int n);
    bus.anodes_i   = an;
    bus.segments_i = sg;
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int k, input logic [6:0] sg);
    drive(~(8'b1 << k), sg, 10);
    drive(8'hFF, 7'h7F, 2);
  endtask

  // scan digits hi..lo of val; optional glitch after digit 3, optional bad
  // segment pattern on digit 3
  task automatic scan(input logic [31:0] val, input int hi, input int lo,
                      input bit glitch, input bit bad3);
    logic [6:0] sg;
    for (int k = hi; k >= lo; k--) begin
      sg = seg_of(val[k*4 +: 4]);
      if (bad3 && k == 3) sg = 7'b1010101;
      show(k, sg);
      if (glitch && k == 3) begin
        drive(8'hFF, 7'h7F, 1);
        drive(8'b11110111, seg_of(4'h8), 2);
        drive(8'hFF, 7'h7F, 1);
      end
    end
  endtask

  int fv0;

  initial begin
    bus.anodes_i   = 8'hFF;
    bus.segments_i = 7'h7F;
    repeat (3) @(negedge clk);
    check("rst_digits", digits_o, 32'h0);
    check("rst_blank", 32'(blank_mask_o), 32'h0);
    check("rst_fv", 32'(frame_valid_o), 32'h0);
    check("rst_err", 32'(digit_err_o), 32'h0);
    check("rst_stalled", 32'(stalled_o), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // clean frame
    fv0 = fv_count;
    exp_q.push_back(32'h00123456);
    scan(32'h00123456, 7, 0, 1'b0, 1'b0);
    check("a_digits", digits_o, 32'h00123456);
    check("a_fv_count", 32'(fv_count - fv0), 32'd1);
    check("a_err", 32'(digit_err_o), 32'h0);
    check("a_blank", 32'(blank_mask_o), 32'h0);
    check("a_stalled", 32'(stalled_o), 32'h0);

    // partial frame (digits 4..0), then reset mid-frame
    scan(32'h00099999, 4, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_digits", digits_o, 32'h0);
    check("mid_rst_blank", 32'(blank_mask_o), 32'h0);
    check("mid_rst_fv", 32'(frame_valid_o), 32'h0);
    check("mid_rst_err", 32'(digit_err_o), 32'h0);
    check("mid_rst_stalled", 32'(stalled_o), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fv0 = fv_count;
    exp_q.push_back(32'h00123456);
    scan(32'h00123456, 7, 1, 1'b0, 1'b0);
    check("b_no_frame_yet", 32'(fv_count - fv0), 32'd0);
    scan(32'h00123456, 0, 0, 1'b0, 1'b0);
    check("b_fv_count", 32'(fv_count - fv0), 32'd1);
    check("b_digits", digits_o, 32'h00123456);

    // glitch of digit 3 showing 8 inside the gap after digit 3
    fv0 = fv_count;
    exp_q.push_back(32'h00123456);
    scan(32'h00123456, 7, 0, 1'b1, 1'b0);
    check("glitch_digits", digits_o, 32'h00123456);
    check("glitch_fv_count", 32'(fv_count - fv0), 32'd1);

    // invalid pattern on digit 3
    exp_q.push_back(32'h0012E456);
    scan(32'h00123456, 7, 0, 1'b0, 1'b1);
    check("inv_nibble", 32'(digits_o[15:12]), 32'hE);
    check("inv_err", 32'(digit_err_o), 32'h1);
    check("inv_blank", 32'(blank_mask_o), 32'h0);

    // following clean frame clears the error
    exp_q.push_back(32'h00123456);
    scan(32'h00123456, 7, 0, 1'b0, 1'b0);
    check("clean_err", 32'(digit_err_o), 32'h0);
    check("clean_digits", digits_o, 32'h00123456);

    // blank digits 7 and 6
    exp_q.push_back(32'hFF123456);
    scan(32'hFF123456, 7, 0, 1'b0, 1'b0);
    check("blank_digits", digits_o, 32'hFF123456);
    check("blank_mask", 32'(blank_mask_o), 32'hC0);
    check("blank_err", 32'(digit_err_o), 32'h0);

    // two anodes low for 20 cycles, then stop scanning
    fv0 = fv_count;
    drive(8'b11110011, seg_of(4'h8), 20);
    drive(8'hFF, 7'h7F, 2);
    check("multi_no_frame", 32'(fv_count - fv0), 32'd0);
    check("multi_digits", digits_o, 32'hFF123456);
    while (cyc < fv_last + TIMEOUT - 1) @(negedge clk);
    check("stall_before", 32'(stalled_o), 32'h0);
    @(negedge clk);
    check("stall_at_timeout", 32'(stalled_o), 32'h1);
    repeat (5) @(negedge clk);
    check("stall_held", 32'(stalled_o), 32'h1);

    // next frame carries the multi-anode error and clears the stall
    fv0 = fv_count;
    exp_q.push_back(32'h87654321);
    scan(32'h87654321, 7, 0, 1'b0, 1'b0);
    check("post_err", 32'(digit_err_o), 32'h1);
    check("post_stalled", 32'(stalled_o), 32'h0);
    check("post_digits", digits_o, 32'h87654321);
    check("post_fv_count", 32'(fv_count - fv0), 32'd1);

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_decoder.md
Name: sevenseg_scan_decoder

Overview:
- Receive side of the multiplexed 7-segment display bus: samples the time-multiplexed anode/segment lines produced by the display driver and reconstructs the 8-digit value being shown.
- Assembles one complete frame per scan sweep and flags blanks, malformed patterns and a stalled scan.
- Used as on-chip display readback/self-check and as the bench-side monitor for the clock/alarm top.

Parameters:
- SETTLE, 4, consecutive cycles a synchronized {anodes,segments} pattern must be stable before capture (≥2).
- TIMEOUT, 200000, cycles without a completed frame before stalled_o asserts.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- anodes_i  input  8  active-low digit select; bit k low = digit k driven (digit 0 rightmost).
- segments_i  input  7  active-low segments, {g,f,e,d,c,b,a}.
- digits_o  output  32  last complete frame; digit k in [4k+3:4k].
- blank_mask_o  output  8  bit k = digit k was blank in last frame.
- frame_valid_o  output  1  one-cycle pulse, coincident with digits_o update.
- digit_err_o  output  1  last frame contained an invalid pattern or multi-anode event.
- stalled_o  output  1  no frame completed within TIMEOUT cycles.

Behaviour:
- Reset (async, rst_n=0): digits_o=0, blank_mask_o=0, frame_valid_o=0, digit_err_o=0, stalled_o=0; internal seen mask, buffer, error-pending, counters cleared; FSM to IDLE. Reset mid-frame discards the partial frame.
- Inputs pass through a 2-flop synchronizer (15 bits) before any use.
- Decode (active-low, a=bit0): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9, 1111111→F (blank). Any other pattern → E, marked invalid.
- Stability counter: cleared when the synchronized pattern differs from the previous cycle, otherwise increments, saturating at SETTLE.
- FSM:
  - IDLE: anodes all-high (normal inter-digit blanking, not an error). Go to SETTLING when exactly one anode is low.
  - SETTLING: capture when the counter reaches SETTLE-1 with the pattern unchanged, then go to HELD. A change of pattern restarts the count. All-high anodes return to IDLE.
  - HELD: no further capture. Go to SETTLING on a new one-hot pattern, or to IDLE on all-high.
  - In any state, ≥2 anodes low: set error-pending, go to IDLE, no capture.
- Latency: a pattern stable at the pins is captured SETTLE+2 cycles after it first appears.
- Capture of digit k:
  - buffer[k] is written with the decoded nibble and seen[k] is set.
  - blank bit k is set if the code is F.
  - error-pending is set if the pattern is invalid.
  - Re-capturing an already-seen digit overwrites buffer[k]; seen is unchanged.
- Frame completion: when a capture makes seen = 8'hFF, the same edge:
  - loads digits_o (including the new nibble), blank_mask_o and digit_err_o (= error-pending including this capture);
  - pulses frame_valid_o for 1 cycle;
  - clears seen, blank bits and error-pending;
  - clears the stall counter and stalled_o.
- Outputs hold until the next frame completes.
- Stall counter: increments every cycle, saturating at TIMEOUT; stalled_o=1 while count == TIMEOUT. Width is the minimum bits needed to hold TIMEOUT.

Test Plan:
- Assert rst_n=0 after 5 of 8 digits captured, release, then scan a full frame → no frame_valid_o until all 8 digits are re-captured; outputs 0 during reset.
- Scan digits 7..0 = 0,0,1,2,3,4,5,6, each held 10 cycles with 2 all-high gap cycles → digits_o=32'h00123456, exactly one frame_valid_o pulse, digit_err_o=0, blank_mask_o=0.
- Inject a 2-cycle glitch pattern (digit 3 showing 8) inside the gap, SETTLE=4 → ignored; frame reads 32'h00123456.
- Drive segments 1010101 on digit 3 → digits_o[15:12]=4'hE, digit_err_o=1; following clean frame → digit_err_o=0.
- Blank digits 7,6 (1111111) → digits_o[31:24]=8'hFF, blank_mask_o=8'hC0, digit_err_o=0.
- Drive anodes_i=8'b11110011 for 20 cycles, then stop scanning → no capture, next frame has digit_err_o=1; with TIMEOUT=100, stalled_o rises 100 cycles after the last frame_valid_o and clears on the next frame.
